// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
//   Instruction register and control sequencer for the simple RISC machine.
//   It latches a 16-bit instruction and steps through one state per clock:
//   WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG and WRITE_IMM. These states
//   drive the register-file read/write ports and the datapath load/select
//   controls. All control outputs are Moore outputs.
//
//   Configuration macro: CTRL_ILLEGAL_TRAP_EN
//     defined   : an illegal opcode traps into HALT (err=1, w=0) until reset.
//     undefined : an illegal opcode returns to WAIT silently, and err stays 0.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   in[15:0]          : instruction word, captured by load while in WAIT
//   load, s           : capture IR / start execution (both sampled in WAIT only)
//   w, err            : idle flag / illegal-opcode trap flag
//   readnum, writenum : register-file read / write addresses
//   write             : register-file write enable
//   loada..loads      : datapath A/B/C/status load enables
//   asel, bsel        : A operand zero / B operand from sximm5
//   vsel[1:0]         : write-back source (00 = C, 10 = sximm8)
//   ALUop, shift      : ALU operation / shifter control
//   sximm8, sximm5    : sign-extended immediates taken from IR
module cpu_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_ADD,
    I_CMP,
    I_AND,
    I_MVN,
    I_ILLEGAL
  } ins_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ins_t        ins;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  function automatic logic signed [15:0] sext8(input logic signed [7:0] v);
    return 16'(v);
  endfunction

  function automatic logic signed [15:0] sext5(input logic signed [4:0] v);
    return 16'(v);
  endfunction

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign sximm8 = sext8(ir_q[7:0]);
  assign sximm5 = sext5(ir_q[4:0]);

  always_comb begin
    ins = I_ILLEGAL;
    case ({opcode, op})
      5'b110_10: ins = I_MOV_IMM;
      5'b110_00: ins = I_MOV_REG;
      5'b101_00: ins = I_ADD;
      5'b101_01: ins = I_CMP;
      5'b101_10: ins = I_AND;
      5'b101_11: ins = I_MVN;
      default:   ins = I_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    ALUop    = 2'b00;
    shift    = 2'b00;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        // A same-cycle load and start executes the newly loaded word,
        // because DECODE looks at IR one cycle later.
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ins)
          I_MOV_IMM:           state_d = S_WRITE_IMM;
          I_MOV_REG, I_MVN:    state_d = S_GET_B;
          I_ADD, I_CMP, I_AND: state_d = S_GET_A;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_WAIT;
`endif
          end
        endcase
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        // MOV reg passes the shifted B through the adder with A forced to 0.
        if (ins == I_MOV_REG) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        // CMP updates only the status flags and never writes back.
        if (ins == I_CMP) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        vsel     = 2'b00;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        write    = 1'b1;
        vsel     = 2'b10;
        state_d  = S_WAIT;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        err     = 1'b1;
        state_d = S_HALT;
      end
`endif
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Instruction register and control state machine that drives the 8×16 register file and surrounding datapath of the simple RISC machine. Latches a 16-bit instruction, decodes it, and sequences `readnum`/`writenum`/`write` plus datapath loads/selects one state per clock, so each instruction reaches the register file as a defined series of read and write cycles. Sits directly upstream of the register file and datapath, below the top-level CPU wrapper.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in` in 16: instruction word.
- `load` in 1: capture `in` into the instruction register (IR).
- `s` in 1: start executing the instruction held in IR.
- `w` out 1: idle; high only in WAIT.
- `err` out 1: illegal-opcode flag. Behaviour depends on the Configuration macro.
- `readnum` out 3: register-file read address.
- `writenum` out 3: register-file write address.
- `write` out 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: load enables for datapath A, B, C and status.
- `asel`, `bsel` out 1 each: A operand forced to 0; B operand taken from `sximm5`.
- `vsel` out 2: write-back source. 00 = C, 10 = `sximm8`; 01 and 11 are never driven.
- `ALUop` out 2: IR[12:11] in EXEC, else 0.
- `shift` out 2: IR[4:3] in GET_B and EXEC, else 0.
- `sximm8` out 16: IR[7:0] sign-extended.
- `sximm5` out 16: IR[4:0] sign-extended.

## Operation
- IR fields:
  - opcode = IR[15:13]; op = IR[12:11].
  - Rn = IR[10:8]; Rd = IR[7:5]; Rm = IR[2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8.
  - 110/00 MOV Rd,Rm{,sh}.
  - 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN.
  - Every other opcode/op combination is illegal.
- IR loads only when `load`=1 and state = WAIT. `load` in any other state is ignored.
- `s` is sampled only in WAIT. `s` while busy is ignored.
- If `load` and `s` are both high in the same WAIT cycle, the new IR value is written and execution starts on the new value.
- Moore outputs. Every control output is 0 unless listed for the current state.
- States and transitions:
  - WAIT: `w`=1. On `s`=1 go to DECODE.
  - DECODE: no outputs.
    - MOV imm goes to WRITE_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Illegal opcode: see Configuration.
  - GET_A: `readnum`=Rn, `loada`=1. Go to GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1. Go to EXEC.
  - EXEC: `ALUop` and `shift` driven.
    - `asel`=1 for MOV reg; `ALUop`=00 is forced for MOV reg.
    - CMP: `loads`=1, `loadc`=0, then go to WAIT.
    - All other instructions: `loadc`=1, then go to WRITE_REG.
  - WRITE_REG: `writenum`=Rd, `write`=1, `vsel`=00. Go to WAIT.
  - WRITE_IMM: `writenum`=Rn, `write`=1, `vsel`=10. Go to WAIT.
  - HALT (macro only): `err`=1. Leaves only on reset.
- `write`=1 in exactly one cycle per writing instruction, and never for CMP or illegal opcodes.

## Timing
- Reset:
  - State = WAIT, IR = 0x0000.
  - All outputs 0 except `w`=1.
  - `sximm8` and `sximm5` are 0x0000.
  - Reset mid-instruction aborts it. No `write` is issued in the cycle after reset.
- Latency, with `s` sampled at edge k:
  - MOV imm: `write` during cycle k+2, `w` high again at k+3.
  - MOV reg / MVN: `write` during cycle k+4, `w` high again at k+5.
  - ADD / AND: `write` during cycle k+5, `w` high again at k+6.
  - CMP: `loads` during cycle k+4, `w` high again at k+5.
- `sximm8` and `sximm5` are continuous functions of IR. They change one cycle after an accepted `load`.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT. `err`=1 and `w`=0 until `reset`; `s` and `load` are ignored.
- Not defined: an illegal opcode in DECODE returns to WAIT with no register-file activity, and `err` is tied to 0.

## Test plan
- Reset, then `load` 0xD007 and `s`=1.
  - `write`=1 two cycles later with `writenum`=0, `vsel`=10, `sximm8`=0x0007.
  - `w`=1 on the next cycle.
- `load` 0xD5FE and `s` in the same cycle.
  - WRITE_IMM drives `writenum`=5 and `sximm8`=0xFFFE.
- ADD 0xA140.
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1.
  - EXEC: `ALUop`=00, `loadc`=1.
  - WRITE_REG: `writenum`=2, `write`=1.
  - 6 cycles in total to `w`.
- MOV reg 0xC069.
  - GET_B: `readnum`=1, `shift`=01.
  - EXEC: `asel`=1.
  - WRITE_REG: `writenum`=3.
- CMP 0xA900: `loads`=1 in EXEC; `write` is never asserted.
- `s` and `load` pulsed mid-ADD: ignored, IR unchanged.
- Reset asserted in EXEC: state goes to WAIT and `write` never fires.
- Illegal 0xE000:
  - With the macro: HALT, `err`=1 until reset.
  - Without the macro: back in WAIT in 2 cycles, `err`=0.
